// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO.
//                Shift-add multiply (LSB first) and restoring divide
//                (MSB first), one bit per cycle, sequenced by a small FSM
//                behind a Start/Busy/Done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;          // bit1: divide, bit0: unsigned
  logic [WIDTH-1:0]     a_q, a_d;            // multiplicand / dividend (magnitude after PREP)
  logic [WIDTH-1:0]     b_q, b_d;            // multiplier / divisor (magnitude after PREP)
  logic [2*WIDTH-1:0]   acc_q, acc_d;        // product, or {remainder, quotient}
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;        // product / quotient must be negated
  logic                 rneg_q, rneg_d;      // remainder takes dividend sign
  logic                 done_q, done_d;
  logic                 divzero_q, divzero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Sign extraction; only signed ops treat the MSB as a sign.
  logic w_signed, w_is_div, w_a_neg, w_b_neg;
  assign w_signed = ~op_q[0];
  assign w_is_div = op_q[1];
  assign w_a_neg  = w_signed & a_q[WIDTH-1];
  assign w_b_neg  = w_signed & b_q[WIDTH-1];

  // Multiply step: add multiplicand into the upper half, then shift right.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};

  // Divide step: shift the next dividend bit into the partial remainder and
  // trial-subtract the divisor; the remainder is always below the divisor,
  // so the low WIDTH bits of the difference are exact when it fits.
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub;
  logic [WIDTH-1:0] w_div_rem;
  assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, b_q});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - b_q;
  assign w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];

  // Sign-corrected results used at commit.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix, w_rem_fix;
  assign w_prod_fix = neg_q  ? -acc_q : acc_q;
  assign w_quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Next-state and datapath sequencing.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          op_d    = Op;
          a_d     = A;
          b_d     = B;
          state_d = PREP;
        end
      end
      PREP: begin
        acc_d = '0;
        cnt_d = '0;
        if (w_is_div && (b_q == '0)) begin
          done_d    = 1'b1;
          divzero_d = 1'b1;
          state_d   = IDLE;
        end else begin
          // Negating 0x80..0 yields 0x80..0, which is read as unsigned 2^(W-1).
          a_d     = w_a_neg ? -a_q : a_q;
          b_d     = w_b_neg ? -b_q : b_q;
          neg_d   = w_a_neg ^ w_b_neg;
          rneg_d  = w_a_neg;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_is_div) begin
          acc_d = {w_div_rem, acc_q[WIDTH-2:0], w_div_ge};
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
          b_d   = {1'b0, b_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (w_is_div) begin
          lo_d = w_quot_fix;
          hi_d = w_rem_fix;
        end else begin
          {hi_d, lo_d} = w_prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset discarding any in-flight op.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide unit for the MIPS multicycle CPU. It executes MULT, MULTU, DIV and DIVU on register operands A and B, and holds the architectural HI/LO registers. The main controller launches an operation with a Start/Busy/Done handshake and stalls in a wait state until Done. The block contains its own iteration datapath (shift-add multiply, restoring divide) and the FSM that sequences it. HI/LO drive the register write-back mux for MFHI/MFLO.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is verified.

Ports:
- Clock  in  1  single system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  launch request; sampled only in IDLE
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched with Start
- A  in  WIDTH  rs operand (multiplicand / dividend); latched with Start
- B  in  WIDTH  rt operand (multiplier / divisor); latched with Start
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle pulse when an operation completes or is refused
- DivZero  out  1  one-cycle pulse coincident with Done for DIV/DIVU with B=0
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register

## Operation
- FSM states and transitions:
  - IDLE: Start=1 → PREP.
  - PREP: divide with B=0 → IDLE; otherwise → RUN.
  - RUN: → FIX after 32 iterations.
  - FIX: → IDLE.
- IDLE, edge with Start=1:
  - Latch Op, A and B into internal regs.
  - A and B may change afterwards with no effect.
- PREP:
  - Signed ops (MULT, DIV): convert each operand to its magnitude and record sign bits. Unsigned ops use operands as-is.
  - Clear the 64-bit accumulator and the 5-bit iteration counter.
- RUN, one iteration per cycle, counter 0..31; exit to FIX on the edge where counter=31.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first, into a 64-bit product.
  - Divide: restoring, one quotient bit per cycle, MSB first; 33-bit trial subtract.
- FIX, sign correction and commit:
  - Multiply: negate the 64-bit product if the operand signs differ (signed op only). {Hi,Lo} ← product.
  - Divide: Lo ← quotient, negated if the signs differ. Hi ← remainder, taking the dividend's sign. Signed op only.
  - Done=1 on the next cycle.
- Divide by zero:
  - Detected in PREP; no iterations run.
  - Hi and Lo are left unchanged.
  - Done=1 and DivZero=1 for one cycle; the main controller raises the exception.
- Arithmetic corner cases:
  - 0x80000000 magnitude is handled as unsigned 2^31.
  - DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0 (wraps), DivZero=0.
  - MULT 0x80000000*0x80000000 → {Hi,Lo}=0x4000000000000000.
- Start while Busy=1 is ignored; it is neither queued nor errored.
- Hi/Lo change only at the FIX commit edge or on Reset.

## Timing
- Reset (sync, any state including mid-RUN):
  - Next state IDLE.
  - Busy=0, Done=0, DivZero=0, Hi=0, Lo=0; counter and accumulator cleared.
  - An in-flight operation is discarded.
- Normal latency, with Start sampled at edge E0:
  - PREP after E0.
  - RUN after E1 through E33.
  - FIX after E33.
  - Commit at E34: Hi/Lo valid and Done=1 in the cycle after E34.
  - Busy=1 from after E0 until E34. Total: 34 edges from Start to Done.
- Divide-by-zero latency: PREP after E0; Done=DivZero=1 and Busy=0 after E1.
- Back-to-back: Start may be high in the Done cycle, since state is IDLE. It is accepted at that edge with no dead cycle.
- Done and DivZero are registered outputs, high for exactly one cycle.
- Reset has priority over Start on the same edge.

## Test plan
- Reset, then MULTU 0xFFFFFFFF×0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001. Done exactly 34 edges after the Start edge; Busy high for 34 cycles.
- MULT 0xFFFFFFFD(−3)×0x0000000B(11) → Hi=0xFFFFFFFF, Lo=0xFFFFFFDF. Also MULT 0x80000000×0x80000000 → Hi=0x40000000, Lo=0.
- DIV 0xFFFFFFF9(−7)/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7/2 → Lo=3, Hi=1. DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Preload Hi/Lo via a MULTU 2×3 (Hi=0, Lo=6), then DIV 5/0 → Done and DivZero high together after 2 edges; Hi=0 and Lo=6 unchanged.
- Start pulsed at counter=5 while Busy → ignored, and the result equals the original op. Start held high in the Done cycle → second op accepted immediately, its Done 34 edges later.
- Reset asserted at counter=10 → next cycle Busy=0, Hi=Lo=0, no Done pulse. A fresh MULTU 4×5 then yields Lo=20.
